// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// Build option: define MC_CTRL_ILLEGAL_TRAP_EN to add the illegal-opcode trap state.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif
  } ctrl_t;

  // Control word shown while reset is held: FETCH selects, every enable low.
  function automatic ctrl_t reset_ctrl();
    ctrl_t c;
    c         = '0;
    c.alusrcb = SRCB_FOUR;
    c.aluop   = ALUOP_ADD;
    c.pcsrc   = PCSRC_ALU;
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the main FSM (master) and the multi-cycle datapath (slave).
// Build option MC_CTRL_ILLEGAL_TRAP_EN does not change this bundle.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  // Memory handshake: a request (memread/memwrite) is accepted in the cycle
  // mem_ready is high; the FSM holds the request and its state until then.
  logic       mem_ready;
  logic       pcwrite;
  logic       branch;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;

  modport master (
    input  op, mem_ready,
    output pcwrite, branch, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc, aluop
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, branch, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc, aluop
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Pure state -> control word decoder for the main control FSM.
// Build option MC_CTRL_ILLEGAL_TRAP_EN adds the TRAP decode.
module mc_ctrl_outdec
  import mc_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // irwrite/pcwrite are qualified by mem_ready in the FSM top
        ctrl.memread = 1'b1;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH2;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = PCSRC_JUMP;
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath: state register, next-state logic.
// Build option MC_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes trap in S_TRAP and raise illegal_op.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  mc_ctrl_fsm_if.master      bus,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic               illegal_op,
`endif
  output logic [STATE_W-1:0] state_o
);

  state_t state;
  ctrl_t  dec;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BEQ;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            default:      state <= S_TRAP;
`else
            default:      state <= S_FETCH;
`endif
          endcase
        end
        S_MEMADR: state <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BEQ:    state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_TRAP:   state <= S_TRAP;
`endif
        default:  state <= S_FETCH;
      endcase
    end
  end

  mc_ctrl_outdec u_outdec (
    .state (state),
    .ctrl  (dec)
  );

  // The instruction load and PC increment happen only when the fetch completes.
  always_comb begin
    ctrl = dec;
    if (state == S_FETCH) begin
      ctrl.irwrite = dec.irwrite & bus.mem_ready;
      ctrl.pcwrite = dec.pcwrite & bus.mem_ready;
    end
    if (rst) ctrl = reset_ctrl();
  end

  assign bus.pcwrite  = ctrl.pcwrite;
  assign bus.branch   = ctrl.branch;
  assign bus.iord     = ctrl.iord;
  assign bus.memread  = ctrl.memread;
  assign bus.memwrite = ctrl.memwrite;
  assign bus.irwrite  = ctrl.irwrite;
  assign bus.memtoreg = ctrl.memtoreg;
  assign bus.regdst   = ctrl.regdst;
  assign bus.regwrite = ctrl.regwrite;
  assign bus.alusrca  = ctrl.alusrca;
  assign bus.alusrcb  = ctrl.alusrcb;
  assign bus.pcsrc    = ctrl.pcsrc;
  assign bus.aluop    = ctrl.aluop;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = ctrl.illegal;
`endif

  assign state_o = rst ? '0 : STATE_W'(state);

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main control state machine for the multi-cycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the datapath mux selects and write enables.
- Produces the 2-bit aluop consumed by the ALU-control decoder: 00 add, 01 sub, 10 funct-decoded.
- Stalls on a memory ready handshake so that variable-latency memory is tolerated.

Parameters:
- STATE_W, 4, width of the state register and of the state_o debug port; must be ≥4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  6  opcode field instr[31:26] from the instruction register.
- mem_ready  input  1  memory completes the current access this cycle.
- pcwrite  output  1  unconditional PC write enable.
- branch  output  1  conditional PC write; PC loads when branch & zero.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  output  1  memory read request.
- memwrite  output  1  memory write request.
- irwrite  output  1  instruction register load.
- memtoreg  output  1  writeback data select: 1 = MDR, 0 = ALUOut.
- regdst  output  1  destination select: 1 = rd, 0 = rt.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  output  2  ALU B select: 00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2.
- pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- aluop  output  2  to ALU control: 00 add, 01 sub, 10 funct.
- state_o  output  STATE_W  current state, for debug and the bench.

Behaviour:
- Outputs are Moore (decoded from state only), except that irwrite/pcwrite in FETCH and the memory-state advance are qualified by mem_ready.
- When an output is not listed for a state, it is 0.
- Opcodes handled: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and transitions:
  - FETCH(0): memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. While mem_ready=0: hold, irwrite=0, pcwrite=0. When mem_ready=1: irwrite=1, pcwrite=1, go to DECODE.
  - DECODE(1): alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op: lw/sw→MEMADR, R→EXEC, beq→BEQ, addi→ADDIEX, j→JUMP, other→FETCH.
  - MEMADR(2): alusrca=1, alusrcb=10, aluop=00. lw→MEMRD, sw→MEMWR.
  - MEMRD(3): memread=1, iord=1. Holds until mem_ready, then →MEMWB.
  - MEMWB(4): regwrite=1, memtoreg=1, regdst=0. →FETCH.
  - MEMWR(5): memwrite=1, iord=1. Holds until mem_ready, then →FETCH. memwrite stays high every hold cycle.
  - EXEC(6): alusrca=1, alusrcb=00, aluop=10. →ALUWB.
  - ALUWB(7): regwrite=1, regdst=1, memtoreg=0. →FETCH.
  - BEQ(8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. →FETCH.
  - ADDIEX(9): alusrca=1, alusrcb=10, aluop=00. →ADDIWB.
  - ADDIWB(10): regwrite=1, regdst=0, memtoreg=0. →FETCH.
  - JUMP(11): pcwrite=1, pcsrc=10. →FETCH.
- op is sampled in DECODE and MEMADR only; it must be stable while IR is not written.
- Latencies with zero-wait memory: R 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3.
- Reset:
  - rst=1 at a clock edge forces state=FETCH regardless of current state, including mid-MEMWR.
  - While rst=1, all write enables (pcwrite, branch, memwrite, irwrite, regwrite) and memread are forced 0 combinationally.
  - Selects show FETCH values; state_o=0.
- Undefined state encodings (12–15) → FETCH on the next edge, with all enables 0.

Optional Feature:
- Macro MC_CTRL_ILLEGAL_TRAP_EN.
- When defined:
  - adds output illegal_op (1 bit) and state TRAP(12).
  - DECODE with an unsupported op → TRAP.
  - TRAP asserts illegal_op=1, all enables 0, and self-loops until rst.
- When undefined:
  - no illegal_op port.
  - an unsupported op in DECODE returns to FETCH, acting as a NOP.

Decomposition:
- Shared package mc_pkg holds:
  - state enum/constants S_FETCH..S_TRAP.
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J.
  - aluop constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - alusrcb and pcsrc encodings.
- One natural sub-module: mc_ctrl_outdec, a pure combinational state→control-word decoder. The FSM top holds the state register and next-state logic.

Test Plan:
- rst=1 for 2 cycles from an arbitrary state → state_o=0, pcwrite=irwrite=regwrite=memwrite=0. First cycle after release with mem_ready=1: irwrite=1, pcwrite=1, alusrcb=01.
- lw (op=100011), mem_ready tied 1 → states 0,1,2,3,4,0. aluop=00 in 2. regwrite=1 and memtoreg=1 only in 4. Total 5 cycles.
- R-type (op=000000) → EXEC shows aluop=10, alusrcb=00. ALUWB shows regwrite=1, regdst=1. beq (op=000100) → BEQ shows aluop=01, branch=1, pcsrc=01.
- sw (op=101011) with mem_ready low for 3 cycles in MEMWR → state holds 5, memwrite=1 for 4 cycles, then FETCH. FETCH with mem_ready=0 for 2 cycles → irwrite stays 0 until mem_ready=1.
- j (op=000010) → JUMP shows pcwrite=1, pcsrc=10, then FETCH. rst asserted during MEMRD → FETCH next edge, no regwrite pulse.
- op=111111 → without MC_CTRL_ILLEGAL_TRAP_EN, DECODE→FETCH. With it defined, state 12, illegal_op=1, held until rst.
